// File: rtl/fp_accum_seq.sv
// Reduces a valid/ready stream of IEEE-754 single operands into one sum per stream, using an external combinational adder.
// Optional FP_ACC_NAN_STICKY_EN: sticky NaN flag forces the stream result to the canonical quiet NaN.
module fp_accum_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_sub_i,
  input  logic                  in_last_i,
  output logic [DATA_WIDTH-1:0] add_a_o,
  output logic [DATA_WIDTH-1:0] add_b_o,
  output logic                  add_symbol_o,
  input  logic [DATA_WIDTH-1:0] add_out_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_WIDTH-1:0]  out_count_o
);

  localparam int unsigned MAG_W = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] signed_in;

  // The adder has an implicit hidden bit, so both signs of zero must bypass it.
  function automatic logic is_zero(input logic [MAG_W-1:0] mag);
    return mag == '0;
  endfunction

`ifdef FP_ACC_NAN_STICKY_EN
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);
  logic nan_q, nan_d;

  function automatic logic is_nan(input logic [MAG_W-1:0] mag);
    return (mag[MAG_W-1:MAG_W-8] == 8'hFF) && (mag[MAG_W-9:0] != '0);
  endfunction
`endif

  assign accept       = in_valid_i & in_ready_q;
  assign signed_in    = {in_data_i[DATA_WIDTH-1] ^ in_sub_i, in_data_i[MAG_W-1:0]};
  assign add_a_o      = acc_q;
  assign add_b_o      = in_data_i;
  assign add_symbol_o = in_sub_i;
  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = acc_q;
  assign out_count_o  = cnt_q;

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef FP_ACC_NAN_STICKY_EN
    nan_d   = nan_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = signed_in;
          cnt_d   = CNT_WIDTH'(1);
          state_d = in_last_i ? DONE : ACCUM;
`ifdef FP_ACC_NAN_STICKY_EN
          nan_d   = is_nan(in_data_i[MAG_W-1:0]);
`endif
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_zero(in_data_i[MAG_W-1:0])) begin
            acc_d = acc_q;
          end else if (is_zero(acc_q[MAG_W-1:0])) begin
            acc_d = signed_in;
          end else begin
            acc_d = add_out_i;
`ifdef FP_ACC_NAN_STICKY_EN
            if (is_nan(add_out_i[MAG_W-1:0])) nan_d = 1'b1;
`endif
          end
`ifdef FP_ACC_NAN_STICKY_EN
          if (is_nan(in_data_i[MAG_W-1:0])) nan_d = 1'b1;
`endif
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          if (in_last_i) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
`ifdef FP_ACC_NAN_STICKY_EN
          nan_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FP_ACC_NAN_STICKY_EN
    if (nan_d && state_q != DONE) acc_d = QNAN;
`endif
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef FP_ACC_NAN_STICKY_EN
      nan_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
`ifdef FP_ACC_NAN_STICKY_EN
      nan_q       <= nan_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq: exact fixed-point reference sums, behavioural adder on the return path.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        in_sub_i = 1'b0;
  logic        in_last_i = 1'b0;
  logic [31:0] add_a_o, add_b_o, add_out_i;
  logic        add_symbol_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [7:0]  out_count_o;

  int checks = 0;
  int failures = 0;
  bit hold = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  count;
    bit          zero;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bd_q[$];
  bit          bs_q[$];

  fp_accum_seq #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_sub_i(in_sub_i), .in_last_i(in_last_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_symbol_o(add_symbol_o), .add_out_i(add_out_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_count_o(out_count_o)
  );

  always #5 clk = ~clk;

  // Float <-> exact fixed point in units of 0.25; stimulus stays in the exactly representable range.
  function automatic longint to_fixed(input logic [31:0] b);
    longint m;
    int sh;
    if (b[30:0] == 31'd0) return 0;
    m  = longint'({1'b1, b[22:0]});
    sh = int'(b[30:23]) - 148;
    if (sh >= 0) m = m << sh;
    else m = m >> (-sh);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] from_fixed(input longint v);
    longint mag;
    longint m;
    int p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    m = (p > 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    return {(v < 0), 8'(p + 125), m[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] b);
    return b[30:23] == 8'hFF;
  endfunction

  // Behavioural adder standing in for the downstream FP add/sub block.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic sym);
    if (is_special(a) || is_special(b)) return 32'h7FC0_0000;
    return from_fixed(to_fixed(a) + (sym ? -to_fixed(b) : to_fixed(b)));
  endfunction

  always_comb add_out_i = model_add(add_a_o, add_b_o, add_symbol_o);

  function automatic logic [31:0] rand_operand();
    longint v;
    if ($urandom % 8 == 0) return ($urandom % 2) ? 32'h8000_0000 : 32'h0;
    v = longint'($urandom_range(256, 1));
    return from_fixed(($urandom % 2) ? -v : v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Reference: plain sum of the signed operands, saturating count.
  task automatic push_expected();
    exp_t   e;
    longint sum = 0;
    bit     nan = 1'b0;
    foreach (bd_q[i]) begin
      if (bd_q[i][30:23] == 8'hFF && bd_q[i][22:0] != 23'd0) nan = 1'b1;
      else sum += bs_q[i] ? -to_fixed(bd_q[i]) : to_fixed(bd_q[i]);
    end
    e.count = (bd_q.size() > 255) ? 8'd255 : 8'(bd_q.size());
`ifdef FP_ACC_NAN_STICKY_EN
    if (nan) begin
      e.data = 32'h7FC0_0000;
      e.zero = 1'b0;
    end else
`endif
    begin
      e.data = from_fixed(sum);
      e.zero = (sum == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!in_ready_o && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (!in_ready_o) timeout("in_ready");
  endtask

  // Drives the queued beats; returns 1 time unit after the final accepting edge.
  task automatic play(input bit with_last, input bit gaps);
    if (with_last) push_expected();
    foreach (bd_q[i]) begin
      if (gaps && i > 0 && $urandom % 4 == 0) begin
        in_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      in_valid_i = 1'b1;
      in_data_i  = bd_q[i];
      in_sub_i   = bs_q[i];
      in_last_i  = with_last && (i == bd_q.size() - 1);
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    bd_q.delete();
    bs_q.delete();
  endtask

  task automatic beat(input logic [31:0] d, input bit s);
    bd_q.push_back(d);
    bs_q.push_back(s);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  // Downstream back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready_i = hold ? 1'b0 : ($urandom % 4 != 0);
    end
  end

  // Monitor: a handshake happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %08h expected none", out_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.zero) check("out_data_zero", {1'b0, out_data_o[30:0]}, 32'h0);
        else check("out_data", out_data_o, e.data);
        check("out_count", {24'h0, out_count_o}, {24'h0, e.count});
      end
    end
  end

  initial begin
    int n;
    #12;
    check("rst_in_ready", {31'h0, in_ready_o}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("rst_out_data", out_data_o, 32'h0);
    check("rst_out_count", {24'h0, out_count_o}, 32'h0);
    check("rst_add_a", add_a_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 + 2 + 0.5 = 3.5, result valid right after the last accept.
    hold = 1'b1;
    @(posedge clk); #2;
    beat(32'h3F80_0000, 1'b0); beat(32'h4000_0000, 1'b0); beat(32'h3F00_0000, 1'b0);
    play(1'b1, 1'b0);
    check("latency_out_valid", {31'h0, out_valid_o}, 32'h1);
    check("add_b_passthru", add_b_o, in_data_i);
    hold = 1'b0;
    drain();

    // One-beat subtracted stream.
    beat(32'h4000_0000, 1'b1);
    play(1'b1, 1'b0);
    check("one_beat_valid", {31'h0, out_valid_o}, 32'h1);
    drain();

    // Zero handling on both operand sides.
    beat(32'h0000_0000, 1'b0); beat(32'h3F80_0000, 1'b0);
    play(1'b1, 1'b0);
    beat(32'h3F80_0000, 1'b0); beat(32'h8000_0000, 1'b0);
    play(1'b1, 1'b0);
    drain();

    // Back-pressure: result and count held, no input accepted.
    hold = 1'b1;
    @(posedge clk); #2;
    beat(32'h4040_0000, 1'b0); beat(32'h3F80_0000, 1'b1);
    play(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'h0, out_valid_o}, 32'h1);
      check("stall_in_ready", {31'h0, in_ready_o}, 32'h0);
      check("stall_data", out_data_o, 32'h4000_0000);
      check("stall_count", {24'h0, out_count_o}, 32'h2);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    drain();
    check("post_hs_in_ready", {31'h0, in_ready_o}, 32'h1);
    check("post_hs_valid", {31'h0, out_valid_o}, 32'h0);

    // Asynchronous reset in the middle of a stream.
    beat(32'h3F80_0000, 1'b0); beat(32'h4000_0000, 1'b0);
    play(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'h0, in_ready_o}, 32'h1);
    check("abort_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("abort_out_data", out_data_o, 32'h0);
    check("abort_out_count", {24'h0, out_count_o}, 32'h0);
    check("abort_add_a", add_a_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(32'h3F80_0000, 1'b0);
    play(1'b1, 1'b0);
    drain();

`ifdef FP_ACC_NAN_STICKY_EN
    beat(32'h3F80_0000, 1'b0); beat(32'h7FC0_0001, 1'b0); beat(32'h4000_0000, 1'b0);
    play(1'b1, 1'b0);
    beat(32'h3F80_0000, 1'b0);
    play(1'b1, 1'b0);
    drain();
`endif

    // Random streams with gaps and back-pressure.
    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) beat(rand_operand(), 1'($urandom % 2));
      play(1'b1, 1'b1);
    end
    drain();

    // Long stream: counter saturates while summing continues.
    for (int i = 0; i < 300; i++) beat(rand_operand(), 1'($urandom % 2));
    play(1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
